// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline control for the 5-stage ARM core.
// A small destination-register scoreboard follows the last TRACK_STAGES issued
// instructions and raises a stall (freeze + bubble) when the ID-stage
// instruction reads a register still in flight. An EXE-stage taken branch
// becomes a one-cycle flush with the PC redirected to the branch target.
// Saturating stall/flush event counters are provided for performance analysis.
//
// Build option: define FORWARDING_EN when EXE/MEM results are forwarded; only
// a load in entry 0 (load-use) then stalls. Default build: any match stalls.
//
// Flow control: the ID instruction (id_valid) advances into ID_Stage_Reg on a
// rising clk edge only when freeze=0 and flush=0; hazard=1 means the
// instruction is held in ID and a bubble enters ID_Stage_Reg instead, and
// ext_stall holds the whole pipe (scoreboard and counters included).
module pipe_hazard_ctrl #(
   parameter int ADDRESS_LEN         = 32,
   parameter int REGFILE_ADDRESS_LEN = 4,
   parameter int TRACK_STAGES        = 2,
   parameter int CNT_W               = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           id_valid,
   input  logic [REGFILE_ADDRESS_LEN-1:0] id_src1,
   input  logic [REGFILE_ADDRESS_LEN-1:0] id_src2,
   input  logic                           id_src1_used,
   input  logic                           id_src2_used,
   input  logic                           id_wb_en,
   input  logic [REGFILE_ADDRESS_LEN-1:0] id_dest,
   input  logic                           id_mem_read,
   input  logic                           branch_taken,
   input  logic [ADDRESS_LEN-1:0]         branch_addr,
   input  logic                           ext_stall,
   output logic                           freeze,
   output logic                           hazard,
   output logic                           flush,
   output logic [ADDRESS_LEN-1:0]         redirect_addr,
   output logic [CNT_W-1:0]               stall_cnt,
   output logic [CNT_W-1:0]               flush_cnt
);

   // Scoreboard: entry 0 is the instruction now in ID_Stage_Reg, entry k is
   // k stages further down the pipe.
   logic [TRACK_STAGES-1:0]        sb_valid;
   logic [TRACK_STAGES-1:0]        sb_load;
   logic [REGFILE_ADDRESS_LEN-1:0] sb_dest [TRACK_STAGES];

   logic [TRACK_STAGES-1:0] entry_hit;
   logic [TRACK_STAGES-1:0] load_stall_mask;
   logic [TRACK_STAGES-1:0] alu_stall_mask;
   logic                    any_stall_match;
   logic                    issue;

   // Per-entry source match: a read source equals a valid in-flight destination.
   always_comb begin
      entry_hit = '0;
      for (int k = 0; k < TRACK_STAGES; k++) begin
         entry_hit[k] = sb_valid[k] &
                        ((id_src1_used & (sb_dest[k] == id_src1)) |
                         (id_src2_used & (sb_dest[k] == id_src2)));
      end
   end

   // Which producers can still block a reader: loads and ALU results differ
   // only when forwarding covers ALU results and later load stages.
   always_comb begin
      load_stall_mask = '0;
      alu_stall_mask  = '0;
`ifdef FORWARDING_EN
      load_stall_mask[0] = sb_load[0];
`else
      load_stall_mask = sb_load;
      alu_stall_mask  = ~sb_load;
`endif
   end

   assign any_stall_match = |(entry_hit & (load_stall_mask | alu_stall_mask));

   // Combinational pipe controls; the branch flush outranks a RAW stall and
   // an external hold outranks both.
   assign flush         = branch_taken & ~ext_stall;
   assign hazard        = id_valid & ~flush & ~ext_stall & any_stall_match;
   assign freeze        = hazard | ext_stall;
   assign redirect_addr = flush ? branch_addr : '0;

   // Only a real register-writing instruction that actually leaves ID occupies entry 0.
   assign issue = id_valid & id_wb_en & ~hazard & ~flush;

   // Scoreboard shift: new entry at 0, older entries age by one stage; hold on ext_stall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sb_valid <= '0;
         sb_load  <= '0;
         for (int k = 0; k < TRACK_STAGES; k++) begin
            sb_dest[k] <= '0;
         end
      end else if (!ext_stall) begin
         sb_valid[0] <= issue;
         sb_load[0]  <= issue & id_mem_read;
         sb_dest[0]  <= issue ? id_dest : '0;
         for (int k = 1; k < TRACK_STAGES; k++) begin
            sb_valid[k] <= sb_valid[k-1];
            sb_load[k]  <= sb_load[k-1];
            sb_dest[k]  <= sb_dest[k-1];
         end
      end
   end

   // Saturating event counters; hazard and flush are already zero during ext_stall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (hazard && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (flush && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

endmodule
